// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants for the common-data-bus writeback arbiter.
//   CDB_IDX_W    default ROB index width
//   CDB_DATA_W   default result value width
//   ROB_IDX_NONE ROB index meaning "no result"
//   CDB_SEL_W    width of requester ids / round-robin pointer (up to 4 requesters)
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int CDB_IDX_W    = 3;
  localparam int CDB_DATA_W   = 32;
  localparam int ROB_IDX_NONE = 0;
  localparam int CDB_SEL_W    = 2;

endpackage

// File: rtl/cdb_arbiter_queue.sv
// -----------------------------------------------------------------------------
// result_queue
// Small FIFO holding tagged results for one execution unit.
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear; overrides push and pop in the same cycle
//   push      write wdata (ignored when full)
//   pop       drop the head entry (ignored when empty)
//   wdata     entry to write
//   rdata     current head entry (combinational, valid when !empty)
//   count     occupancy 0..QDEPTH
//   full      count == QDEPTH
//   empty     count == 0
// -----------------------------------------------------------------------------
module result_queue #(
  parameter int WIDTH  = 35,
  parameter int QDEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH+1);

  logic [WIDTH-1:0] mem_reg [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(QDEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rdata   = mem_reg[rd_ptr_reg];
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter sharing the ROB result-writeback path between several
// execution units. Each unit pushes {ROB index, value} into its own queue;
// one head per cycle is registered onto the common data bus.
//   clk, rst   clock, asynchronous active-high reset
//   flush      synchronous clear of all queued results (redirect)
//   req_valid  per-requester result present
//   req_num    per-requester ROB index, slice [k*IDX_W +: IDX_W]; 0 = none
//   req_value  per-requester value, slice [k*DATA_W +: DATA_W]
//   req_ready  per-requester queue not full (0 while rst is high)
//   cdb_num    registered ROB index written back; 0 = bus idle
//   cdb_value  registered value for cdb_num
//   cdb_src    registered id of the winning requester; 0 when idle
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = CDB_IDX_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int QDEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]  req_num,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [IDX_W-1:0]          cdb_num,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [1:0]                cdb_src
);

  localparam int ENTRY_W = IDX_W + DATA_W;
  localparam int CNT_W   = $clog2(QDEPTH+1);
  localparam int SEL_W   = CDB_SEL_W;

  logic [NUM_REQ-1:0] q_push;
  logic [NUM_REQ-1:0] q_pop;
  logic [NUM_REQ-1:0] q_full;
  logic [NUM_REQ-1:0] q_empty;
  logic [ENTRY_W-1:0] q_head  [NUM_REQ];
  logic [CNT_W-1:0]   q_count [NUM_REQ];

  logic [SEL_W-1:0]   rr_ptr_reg;
  logic [SEL_W-1:0]   rr_ptr_next;
  logic               win_valid;
  logic [SEL_W-1:0]   win_id;
  logic [ENTRY_W-1:0] win_head;

  logic [IDX_W-1:0]   cdb_num_reg;
  logic [DATA_W-1:0]  cdb_value_reg;
  logic [SEL_W-1:0]   cdb_src_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      // Ready reflects occupancy only; a pop in this cycle does not free a slot early.
      assign req_ready[gi] = !rst && (q_count[gi] < CNT_W'(QDEPTH));

      // Index 0 is "no result" and is dropped; flush discards same-cycle pushes.
      assign q_push[gi] = req_valid[gi] && !q_full[gi] && !flush &&
                          (req_num[gi*IDX_W +: IDX_W] != IDX_W'(ROB_IDX_NONE));

      assign q_pop[gi] = win_valid && (win_id == SEL_W'(gi));

      result_queue #(
        .WIDTH  (ENTRY_W),
        .QDEPTH (QDEPTH)
      ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (q_push[gi]),
        .pop   (q_pop[gi]),
        .wdata ({req_num[gi*IDX_W +: IDX_W], req_value[gi*DATA_W +: DATA_W]}),
        .rdata (q_head[gi]),
        .count (q_count[gi]),
        .full  (q_full[gi]),
        .empty (q_empty[gi])
      );
    end
  endgenerate

  // First non-empty queue starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int k;
    k         = 0;
    win_valid = 1'b0;
    win_id    = '0;
    win_head  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr_reg) + i) % NUM_REQ;
      if (!win_valid && !q_empty[k]) begin
        win_valid = 1'b1;
        win_id    = SEL_W'(k);
        win_head  = q_head[k];
      end
    end
    rr_ptr_next = (win_id == SEL_W'(NUM_REQ-1)) ? '0 : win_id + SEL_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_num_reg   <= '0;
      cdb_value_reg <= '0;
      cdb_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (flush) begin
      cdb_num_reg   <= '0;
      cdb_value_reg <= '0;
      cdb_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (win_valid) begin
      cdb_num_reg   <= win_head[DATA_W +: IDX_W];
      cdb_value_reg <= win_head[DATA_W-1:0];
      cdb_src_reg   <= win_id;
      rr_ptr_reg    <= rr_ptr_next;
    end else begin
      // Idle bus; the pointer keeps its position.
      cdb_num_reg   <= '0;
      cdb_value_reg <= '0;
      cdb_src_reg   <= '0;
    end
  end

  assign cdb_num   = cdb_num_reg;
  assign cdb_value = cdb_value_reg;
  assign cdb_src   = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 3;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*IDX_W-1:0]  req_num;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        req_ready;
  logic [IDX_W-1:0]          cdb_num;
  logic [DATA_W-1:0]         cdb_value;
  logic [1:0]                cdb_src;

  int checks;
  int failures;
  int cyc;

  cdb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W),
    .DATA_W  (DATA_W),
    .QDEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_num   (cdb_num),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [2:0] num, input logic [31:0] val);
    req_num[k*IDX_W +: IDX_W]    = num;
    req_value[k*DATA_W +: DATA_W] = val;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d valid=%b ready=%b flush=%b cdb_num=%0d cdb_src=%0d cdb_value=0x%0h",
             cyc, req_valid, req_ready, flush, cdb_num, cdb_src, cdb_value);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_num"},   64'(cdb_num),   64'(0));
    check({tag, "_src"},   64'(cdb_src),   64'(0));
    check({tag, "_value"}, 64'(cdb_value), 64'(0));
  endtask

  // Backpressure trace: rr_ptr=1 and empty queues at the start.
  int exp_bp_num  [9] = '{0, 4, 1, 5, 2, 6, 3, 7, 0};
  int exp_bp_src  [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int exp_bp_rdy0 [5] = '{1, 1, 0, 1, 0};
  int exp_ct_num  [4] = '{1, 2, 4, 0};
  int exp_ct_src  [4] = '{0, 1, 2, 0};
  int exp_ct_val  [4] = '{32'h11, 32'h22, 32'h44, 0};

  initial begin
    int i0;
    int i1;
    logic acc0;
    logic acc1;
    int n;
    logic [31:0] ev;

    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; flush = 1'b0;
    req_valid = '0; req_num = '0; req_value = '0;

    // Reset state
    tick(); tick();
    check("rst_ready", 64'(req_ready), 64'(0));
    check_idle("rst");
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(req_ready), 64'(3'b111));

    // Idle
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_num", 64'(cdb_num), 64'(0));
      check("idle_src", 64'(cdb_src), 64'(0));
      check("idle_ready", 64'(req_ready), 64'(3'b111));
    end

    // Single requester 1
    set_req(1, 3'd3, 32'h42); req_valid = 3'b010;
    tick(); req_valid = '0;
    check("single_not_yet", 64'(cdb_num), 64'(0));
    tick();
    check("single_num", 64'(cdb_num), 64'(3));
    check("single_value", 64'(cdb_value), 64'(32'h42));
    check("single_src", 64'(cdb_src), 64'(1));
    tick();
    check_idle("single_after");

    // Flush an idle arbiter to put rr_ptr back at 0
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_idle_ready", 64'(req_ready), 64'(3'b111));

    // Contention, rr_ptr=0
    set_req(0, 3'd1, 32'h11); set_req(1, 3'd2, 32'h22); set_req(2, 3'd4, 32'h44);
    req_valid = 3'b111;
    tick(); req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_num", 64'(cdb_num), 64'(exp_ct_num[i]));
      check("cont_src", 64'(cdb_src), 64'(exp_ct_src[i]));
      check("cont_value", 64'(cdb_value), 64'(exp_ct_val[i]));
    end

    // rr_ptr back at 0: requester 0 beats requester 2
    set_req(0, 3'd5, 32'h55); set_req(2, 3'd6, 32'h66); req_valid = 3'b101;
    tick(); req_valid = '0;
    tick();
    check("rr0_first_num", 64'(cdb_num), 64'(5));
    check("rr0_first_src", 64'(cdb_src), 64'(0));
    tick();
    check("rr0_second_num", 64'(cdb_num), 64'(6));
    check("rr0_second_src", 64'(cdb_src), 64'(2));

    // Single requester 0 leaves rr_ptr=1
    set_req(0, 3'd7, 32'h77); req_valid = 3'b001;
    tick(); req_valid = '0;
    tick();
    check("single0_num", 64'(cdb_num), 64'(7));
    check("single0_value", 64'(cdb_value), 64'(32'h77));

    // Backpressure: req 0 pushes 1,2,3 while req 1 streams 4..7
    i0 = 0; i1 = 0;
    for (int e = 0; e < 9; e++) begin
      req_valid[0] = (i0 < 3);
      req_valid[1] = (i1 < 4);
      set_req(0, 3'(i0 + 1), 32'(32'hA1 + i0));
      set_req(1, 3'(i1 + 4), 32'(32'hB4 + i1));
      if (e < 5) check("bp_ready0", 64'(req_ready[0]), 64'(exp_bp_rdy0[e]));
      acc0 = req_valid[0] && req_ready[0];
      acc1 = req_valid[1] && req_ready[1];
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
      n  = exp_bp_num[e];
      ev = (n == 0) ? 32'h0 : ((n < 4) ? 32'(32'hA0 + n) : 32'(32'hB0 + n));
      check("bp_num", 64'(cdb_num), 64'(n));
      check("bp_src", 64'(cdb_src), 64'(exp_bp_src[e]));
      check("bp_value", 64'(cdb_value), 64'(ev));
    end
    req_valid = '0;
    check("bp_accepts0", 64'(i0), 64'(3));
    check("bp_accepts1", 64'(i1), 64'(4));

    // Index 0 filter on requester 2 (rr_ptr=2)
    set_req(2, 3'd0, 32'hDEAD); req_valid = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) req_valid = '0;
      check_idle("idx0");
      check("idx0_ready", 64'(req_ready), 64'(3'b111));
    end

    // Flush with queues holding 2,1,1
    set_req(0, 3'd1, 32'h11); set_req(1, 3'd2, 32'h22); set_req(2, 3'd4, 32'h44);
    req_valid = 3'b111;
    tick();
    check("fl_fill_a", 64'(cdb_num), 64'(0));
    set_req(0, 3'd3, 32'h33); set_req(2, 3'd6, 32'h66); req_valid = 3'b101;
    tick();
    check("fl_fill_b_num", 64'(cdb_num), 64'(4));
    check("fl_fill_b_src", 64'(cdb_src), 64'(2));
    check("fl_ready_before", 64'(req_ready), 64'(3'b110));
    set_req(0, 3'd7, 32'h70); set_req(1, 3'd7, 32'h71); set_req(2, 3'd7, 32'h72);
    req_valid = 3'b111; flush = 1'b1;
    tick();
    req_valid = '0; flush = 1'b0;
    check_idle("fl_edge");
    check("fl_ready_after", 64'(req_ready), 64'(3'b111));
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("fl_stale");
    end

    // Asynchronous reset mid-operation (rr_ptr=0)
    set_req(0, 3'd5, 32'h55); set_req(1, 3'd6, 32'h66); req_valid = 3'b011;
    tick(); req_valid = '0;
    tick();
    check("ar_before_num", 64'(cdb_num), 64'(5));
    #3 rst = 1'b1;
    #1;
    check_idle("ar_async");
    check("ar_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ar_ready_release", 64'(req_ready), 64'(3'b111));
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("ar_lost");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
